// File: rtl/lc3_selftest_seq_pkg.sv
// Shared types and defaults for the LC3 self-test sequencer.
// Combinational helpers only; no latency, no backpressure.
package lc3_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_DUT,
        ST_GAP,
        ST_RUN_PULSE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int         PULSE_CYC_DEF   = 10;
    localparam int         TIMEOUT_CYC_DEF = 4096;
    localparam logic [7:0] ERRCNT_MAX      = 8'd255;

    // Vector index width, never narrower than one bit.
    function automatic int vec_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lc3_selftest_seq_if.sv
// Bus between the self-test sequencer, its vector lookup and the processor under test.
// Wires only; no latency, no backpressure.
interface lc3_selftest_seq_if #(
    parameter int NUM_VEC = 4
);
    import lc3_test_pkg::*;

    localparam int VW = vec_idx_w(NUM_VEC);

    logic          Start;
    logic [VW-1:0] Vec_idx;
    logic [15:0]   Vec_S;
    logic [15:0]   Vec_Exp;
    logic [15:0]   Obs;
    logic [15:0]   S_out;
    logic          DUT_Reset_n;
    logic          Run_n;
    logic          Continue_n;
    logic          Busy;
    logic          Done;
    logic          Pass;
    logic [7:0]    ErrorCnt;
    logic [7:0]    Fail_idx;

    modport master (
        input  Start, Vec_S, Vec_Exp, Obs,
        output Vec_idx, S_out, DUT_Reset_n, Run_n, Continue_n,
               Busy, Done, Pass, ErrorCnt, Fail_idx
    );

    modport slave (
        output Start, Vec_S, Vec_Exp, Obs,
        input  Vec_idx, S_out, DUT_Reset_n, Run_n, Continue_n,
               Busy, Done, Pass, ErrorCnt, Fail_idx
    );

endinterface

// File: rtl/lc3_selftest_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Load takes effect next edge; a load of N-1 gives N cycles before leaving a phase.
module selftest_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/lc3_selftest_seq.sv
// Self-test sequencer: per vector resets the LC3, drives switches, pulses Run, waits for Obs==Vec_Exp or timeout.
// All outputs registered; Start honoured only in IDLE/DONE. LC3_SELFTEST_STOP_ON_FAIL_EN ends the run at the first failure.
module lc3_selftest_seq
    import lc3_test_pkg::*;
#(
    parameter int NUM_VEC     = 4,
    parameter int PULSE_CYC   = PULSE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    lc3_selftest_seq_if.master bus
);

    localparam int VW   = vec_idx_w(NUM_VEC);
    localparam int TW_P = $clog2(PULSE_CYC + 1);
    localparam int TW_T = $clog2(TIMEOUT_CYC + 1);
    localparam int TW   = (TW_P > TW_T) ? TW_P : TW_T;

    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VEC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] TMO_LD   = TW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [VW-1:0] vec_idx, vec_idx_nxt;
    logic [15:0]   s_out, s_out_nxt;
    logic          dut_reset_n, dut_reset_n_nxt;
    logic          run_n, run_n_nxt;
    logic          busy, busy_nxt;
    logic          done, done_nxt;
    logic          pass, pass_nxt;
    logic [7:0]    err_cnt, err_cnt_nxt;
    logic [7:0]    fail_idx, fail_idx_nxt;
    logic          first_fail, first_fail_nxt;

    logic          match;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;
    logic          stop_hit;

    assign match = (bus.Obs == bus.Vec_Exp);

`ifdef LC3_SELFTEST_STOP_ON_FAIL_EN
    assign stop_hit = first_fail;
`else
    assign stop_hit = 1'b0;
`endif

    // Every phase entry reloads the shared timer.
    assign tmr_load = (state_nxt != state);
    assign tmr_val  = (state_nxt == ST_WAIT) ? TMO_LD : PULSE_LD;

    selftest_timer #(.W(TW)) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            vec_idx     <= '0;
            s_out       <= '0;
            dut_reset_n <= 1'b1;
            run_n       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_idx    <= '0;
            first_fail  <= 1'b0;
        end else begin
            state       <= state_nxt;
            vec_idx     <= vec_idx_nxt;
            s_out       <= s_out_nxt;
            dut_reset_n <= dut_reset_n_nxt;
            run_n       <= run_n_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            pass        <= pass_nxt;
            err_cnt     <= err_cnt_nxt;
            fail_idx    <= fail_idx_nxt;
            first_fail  <= first_fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.Start)             state_nxt = ST_RST_DUT;
            ST_RST_DUT:       if (tmr_expired)           state_nxt = ST_GAP;
            ST_GAP:           if (tmr_expired)           state_nxt = ST_RUN_PULSE;
            ST_RUN_PULSE:     if (tmr_expired)           state_nxt = ST_WAIT;
            ST_WAIT:          if (match || tmr_expired)  state_nxt = ST_NEXT;
            ST_NEXT:          state_nxt = (vec_idx == LAST_IDX || stop_hit) ? ST_DONE : ST_RST_DUT;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_idx_nxt    = vec_idx;
        s_out_nxt      = s_out;
        err_cnt_nxt    = err_cnt;
        fail_idx_nxt   = fail_idx;
        first_fail_nxt = first_fail;

        if ((state == ST_IDLE || state == ST_DONE) && bus.Start) begin
            vec_idx_nxt    = '0;
            err_cnt_nxt    = '0;
            fail_idx_nxt   = '0;
            first_fail_nxt = 1'b0;
        end
        // Vec_idx is already current here, so the lookup answers for this vector.
        if (state == ST_RST_DUT) begin
            s_out_nxt = bus.Vec_S;
        end
        if (state == ST_WAIT && !match && tmr_expired) begin
            if (err_cnt != ERRCNT_MAX) begin
                err_cnt_nxt = err_cnt + 8'd1;
            end
            if (!first_fail) begin
                first_fail_nxt = 1'b1;
                fail_idx_nxt   = 8'(vec_idx);
            end
        end
        if (state == ST_NEXT && state_nxt == ST_RST_DUT) begin
            vec_idx_nxt = vec_idx + 1'b1;
        end

        dut_reset_n_nxt = (state_nxt != ST_RST_DUT);
        run_n_nxt       = (state_nxt != ST_RUN_PULSE);
        busy_nxt        = !(state_nxt == ST_IDLE || state_nxt == ST_DONE);
        done_nxt        = (state_nxt == ST_DONE);
        pass_nxt        = done_nxt && (err_cnt_nxt == '0);
    end

    assign bus.Vec_idx     = vec_idx;
    assign bus.S_out       = s_out;
    assign bus.DUT_Reset_n = dut_reset_n;
    assign bus.Run_n       = run_n;
    assign bus.Continue_n  = 1'b1;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.Pass        = pass;
    assign bus.ErrorCnt    = err_cnt;
    assign bus.Fail_idx    = fail_idx;

endmodule
